frame_reader: RTL and testbench
===============================

Name: frame_reader

Overview:
- Read-side egress stage of the packet buffer.
- Accepts a frame descriptor (start block address, byte length) and issues block reads to the dual-port block SRAM (1-cycle read latency).
- Unpacks each BLOCK_BITS word into a byte stream with valid/ready/last toward the egress MAC.
- Returns each fully consumed block address to the free-block allocator.

Parameters:
- BLOCK_BITS, mem_pkg::BLOCK_BITS, SRAM word width; must be a multiple of 8.
- NUM_BLOCKS, mem_pkg::NUM_BLOCKS, blocks in the SRAM; addresses wrap modulo this value.
- ADDR_W, mem_pkg::ADDR_W, block address width.
- LEN_W, 11, frame byte-length width (max 2047 bytes).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- desc_valid  in  1  descriptor offered.
- desc_ready  out  1  descriptor accepted when desc_valid and desc_ready are both high.
- desc_addr  in  ADDR_W  first block of frame.
- desc_len  in  LEN_W  frame length in bytes.
- r_addr  out  ADDR_W  SRAM read address.
- r_data  in  BLOCK_BITS  SRAM read data; valid one cycle after r_addr is presented.
- out_valid  out  1  byte valid.
- out_ready  in  1  downstream accepts the byte.
- out_data  out  8  byte.
- out_last  out  1  final byte of frame.
- free_valid  out  1  one-cycle pulse: block released.
- free_addr  out  ADDR_W  released block address.

Behaviour:
- Only one clock and one reset. Reset is synchronous and active-high (rst sampled on the clk rising edge).
- Reset values: state IDLE, desc_ready=1, out_valid=0, out_last=0, free_valid=0, r_addr=0, out_data=0. All counters cleared.
- Reset mid-frame: the frame is discarded and no free pulses are emitted for its blocks. The allocator is reset alongside this block.
- BPB = BLOCK_BITS/8. Byte k of a block is r_data[8k+7:8k] (byte 0 first).
- FSM states:
  - IDLE: desc_ready=1. On handshake, latch cur_addr=desc_addr and rem=desc_len.
    - desc_len==0: accept, emit nothing, stay in IDLE.
    - otherwise go to FETCH.
  - FETCH: r_addr=cur_addr. Go to LOAD.
  - LOAD: capture r_data into the block buffer. Set byte index idx=0 and blk_bytes=min(rem,BPB). Go to STREAM.
  - STREAM: out_valid=1, out_data=buffer byte idx, out_last=(rem==1). On each out_valid && out_ready: idx++, rem--.
    - On the transfer of byte blk_bytes-1: free_valid=1 and free_addr=cur_addr on the following cycle.
    - cur_addr advances, wrapping NUM_BLOCKS-1 -> 0.
    - If rem becomes 0, go to IDLE; else go to FETCH.
- desc_ready=0 in every state except IDLE.
- Latency: descriptor handshake at edge E gives FETCH in cycle E+1, LOAD in E+2, first out_valid in E+3.
- Without the optional feature, each subsequent block costs 2 bubble cycles.
- out_data, out_last and out_valid are held stable while out_valid && !out_ready.
- Partial last block: bytes beyond blk_bytes are never output.
- Block count per frame = ceil(desc_len/BPB). Exactly that many free pulses are emitted, in address order.
- r_addr holds its last value outside FETCH. No read-enable exists, so stale reads are harmless.

Optional Feature:
- Macro: FRAME_READER_PREFETCH_EN.
- Defined:
  - A second block buffer is added.
  - While streaming block n, if more bytes remain beyond the current block, the read for block n+1 is issued at the first STREAM cycle and captured one cycle later.
  - On the transfer of the last byte of block n, the first byte of block n+1 is presented the next cycle with no bubble.
  - Free-pulse timing and ordering are unchanged.
  - Prefetch never reads past the frame's final block.
- Undefined: the FETCH/LOAD bubble behaviour above.

Test Plan:
- Bench build: BLOCK_BITS=64, NUM_BLOCKS=16, out_ready=1.
- Descriptor addr=3, len=8 -> 8 bytes from block 3 in order, out_last on byte 8, one free pulse addr=3, first out_valid 3 cycles after the handshake.
- addr=15, len=20 -> blocks 15, 0, 1 read; bytes 20 output; last block contributes 4 bytes; free pulses 15, 0, 1.
- len=0 -> no out_valid, no free pulse, desc_ready high again the next cycle; a following descriptor len=1 yields a single byte with out_last=1.
- len=16 with out_ready toggling 1-0-0-1 -> no byte lost or duplicated; outputs held stable while stalled; free pulses after bytes 8 and 16.
- rst asserted at byte 5 of a len=16 frame -> next cycle out_valid=0, desc_ready=1, no further free pulses; a new descriptor streams correctly.
- With FRAME_READER_PREFETCH_EN defined, len=24 -> 24 consecutive out_valid cycles with no gap; without it -> exactly two 2-cycle gaps.

Source files
------------

// File: rtl/mem_pkg.sv
// Packet-buffer memory geometry shared by the block SRAM, allocator and readers.
package mem_pkg;
  localparam int unsigned BLOCK_BITS = 64;
  localparam int unsigned NUM_BLOCKS = 16;
  localparam int unsigned ADDR_W     = $clog2(NUM_BLOCKS);
endpackage

// File: rtl/frame_reader.sv
// frame_reader: read-side egress stage of the packet buffer.
// Takes a frame descriptor (start block, byte length), reads the frame's blocks
// from the block SRAM (1-cycle read latency), unpacks them into a byte stream
// (byte 0 = r_data[7:0]) and returns each fully consumed block to the allocator.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   desc_valid/desc_ready         descriptor handshake; desc_addr, desc_len payload
//   r_addr / r_data               SRAM read address / data (one cycle later)
//   out_valid/out_ready           byte stream handshake; out_data, out_last payload
//   free_valid / free_addr        one-cycle pulse per released block
// Optional feature: define FRAME_READER_PREFETCH_EN to add a second block buffer
// that prefetches the next block so consecutive blocks stream without bubbles.
// Prefetch assumes BLOCK_BITS >= 16 (at least two bytes per block).
module frame_reader #(
  parameter int unsigned BLOCK_BITS = mem_pkg::BLOCK_BITS,
  parameter int unsigned NUM_BLOCKS = mem_pkg::NUM_BLOCKS,
  parameter int unsigned ADDR_W     = mem_pkg::ADDR_W,
  parameter int unsigned LEN_W      = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [ADDR_W-1:0]     desc_addr,
  input  logic [LEN_W-1:0]      desc_len,
  output logic [ADDR_W-1:0]     r_addr,
  input  logic [BLOCK_BITS-1:0] r_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_last,
  output logic                  free_valid,
  output logic [ADDR_W-1:0]     free_addr
);

  localparam int unsigned BPB   = BLOCK_BITS / 8;
  localparam int unsigned IDX_W = (BPB > 1) ? $clog2(BPB) : 1;
  localparam int unsigned BB_W  = $clog2(BPB + 1);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STREAM} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BB_W-1:0]       blk_bytes_q, blk_bytes_d;
  logic [BLOCK_BITS-1:0] buf0_q, buf0_d;
  logic [ADDR_W-1:0]     r_addr_d;
  logic                  out_valid_d, out_last_d, free_valid_d, desc_ready_d;
  logic [7:0]            out_data_d;
  logic [ADDR_W-1:0]     free_addr_d;
  logic [IDX_W-1:0]      idx_nxt;
`ifdef FRAME_READER_PREFETCH_EN
  logic [BLOCK_BITS-1:0] buf1_q, buf1_d;
  logic [BLOCK_BITS-1:0] nxt_blk;
  // 2: read on the bus this cycle, 1: data arriving on r_data this cycle, 0: idle
  logic [1:0]            pf_stage_q, pf_stage_d;
`endif

  // Next block address with wrap at NUM_BLOCKS-1.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(NUM_BLOCKS - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

  // Bytes of the frame carried by the block starting at remaining count r.
  function automatic logic [BB_W-1:0] blk_len(input logic [LEN_W-1:0] r);
    return (r >= LEN_W'(BPB)) ? BB_W'(BPB) : BB_W'(r);
  endfunction

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      rem_q       <= '0;
      idx_q       <= '0;
      blk_bytes_q <= '0;
      buf0_q      <= '0;
      r_addr      <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      free_valid  <= 1'b0;
      free_addr   <= '0;
      desc_ready  <= 1'b1;
`ifdef FRAME_READER_PREFETCH_EN
      buf1_q      <= '0;
      pf_stage_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      blk_bytes_q <= blk_bytes_d;
      buf0_q      <= buf0_d;
      r_addr      <= r_addr_d;
      out_valid   <= out_valid_d;
      out_data    <= out_data_d;
      out_last    <= out_last_d;
      free_valid  <= free_valid_d;
      free_addr   <= free_addr_d;
      desc_ready  <= desc_ready_d;
`ifdef FRAME_READER_PREFETCH_EN
      buf1_q      <= buf1_d;
      pf_stage_q  <= pf_stage_d;
`endif
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    rem_d        = rem_q;
    idx_d        = idx_q;
    blk_bytes_d  = blk_bytes_q;
    buf0_d       = buf0_q;
    r_addr_d     = r_addr;
    out_valid_d  = out_valid;
    out_data_d   = out_data;
    out_last_d   = out_last;
    free_valid_d = 1'b0;
    free_addr_d  = free_addr;
    idx_nxt      = idx_q + IDX_W'(1);
`ifdef FRAME_READER_PREFETCH_EN
    buf1_d       = buf1_q;
    pf_stage_d   = pf_stage_q;
    nxt_blk      = (pf_stage_q == 2'd1) ? r_data : buf1_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (desc_valid) begin
          cur_addr_d = desc_addr;
          rem_d      = desc_len;
          if (desc_len != '0) begin
            state_d  = FETCH;
            r_addr_d = desc_addr;
          end
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        buf0_d      = r_data;
        idx_d       = '0;
        blk_bytes_d = blk_len(rem_q);
        state_d     = STREAM;
        out_valid_d = 1'b1;
        out_data_d  = r_data[7:0];
        out_last_d  = (rem_q == LEN_W'(1));
`ifdef FRAME_READER_PREFETCH_EN
        if (rem_q > LEN_W'(BPB)) begin
          r_addr_d   = next_addr(cur_addr_q);
          pf_stage_d = 2'd2;
        end
`endif
      end
      STREAM: begin
`ifdef FRAME_READER_PREFETCH_EN
        if (pf_stage_q == 2'd2) pf_stage_d = 2'd1;
        if (pf_stage_q == 2'd1) begin
          buf1_d     = r_data;
          pf_stage_d = 2'd0;
        end
`endif
        if (out_ready) begin
          rem_d      = rem_q - LEN_W'(1);
          out_last_d = (rem_q == LEN_W'(2));
          if ((BB_W'(idx_q) + BB_W'(1)) == blk_bytes_q) begin
            // Last byte of this block: release it and move on.
            free_valid_d = 1'b1;
            free_addr_d  = cur_addr_q;
            cur_addr_d   = next_addr(cur_addr_q);
            idx_d        = '0;
            if (rem_q == LEN_W'(1)) begin
              state_d     = IDLE;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
            end else begin
`ifdef FRAME_READER_PREFETCH_EN
              buf0_d      = nxt_blk;
              blk_bytes_d = blk_len(rem_q - LEN_W'(1));
              out_data_d  = nxt_blk[7:0];
              if ((rem_q - LEN_W'(1)) > LEN_W'(BPB)) begin
                r_addr_d   = next_addr(next_addr(cur_addr_q));
                pf_stage_d = 2'd2;
              end
`else
              state_d     = FETCH;
              r_addr_d    = next_addr(cur_addr_q);
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
`endif
            end
          end else begin
            idx_d      = idx_nxt;
            out_data_d = buf0_q[{idx_nxt, 3'b000} +: 8];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    desc_ready_d = (state_d == IDLE);
  end

endmodule

// File: tb/tb_frame_reader.sv
// Scoreboard bench for frame_reader: stimulus pushes expected bytes computed from
// the frame rules; a negedge monitor pops and compares every transferred byte and
// checks that each block-final byte is followed by its free pulse.
module tb_frame_reader;
  localparam int unsigned BB  = 64;
  localparam int unsigned NB  = 16;
  localparam int unsigned AW  = 4;
  localparam int unsigned LW  = 11;
  localparam int unsigned BPB = BB / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          desc_valid = 1'b0;
  logic          desc_ready;
  logic [AW-1:0] desc_addr = '0;
  logic [LW-1:0] desc_len = '0;
  logic [AW-1:0] r_addr;
  logic [BB-1:0] r_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    out_data;
  logic          out_last;
  logic          free_valid;
  logic [AW-1:0] free_addr;

  frame_reader #(.BLOCK_BITS(BB), .NUM_BLOCKS(NB), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_addr(desc_addr), .desc_len(desc_len),
    .r_addr(r_addr), .r_data(r_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .free_valid(free_valid), .free_addr(free_addr)
  );

  always #5 clk = ~clk;

  // Block SRAM model with one cycle of read latency.
  logic [BB-1:0] mem [NB];
  always @(posedge clk) r_data <= mem[r_addr];

  typedef struct {
    logic [7:0]    data;
    bit            last;
    bit            blk_end;
    logic [AW-1:0] faddr;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int bytes_seen = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: byte i of a frame lives in block (addr + i/BPB) mod NB at lane i%BPB.
  task automatic push_frame(input int addr, input int len);
    exp_t e;
    logic [BB-1:0] w;
    int blk;
    for (int i = 0; i < len; i++) begin
      blk       = (addr + i / BPB) % NB;
      w         = mem[blk];
      e.data    = w[8*(i % BPB) +: 8];
      e.last    = (i == len - 1);
      e.blk_end = ((i % BPB) == BPB - 1) || (i == len - 1);
      e.faddr   = AW'(blk);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compares transfers and free pulses, and holds stalled outputs stable.
  bit            free_due = 0;
  logic [AW-1:0] due_addr = '0;
  bit            prev_stall = 0;
  logic [7:0]    prev_data = '0;
  bit            prev_last = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      free_due   = 0;
      prev_stall = 0;
    end else begin
      check("free_valid", 64'(free_valid), 64'(free_due));
      if (free_due) check("free_addr", 64'(free_addr), 64'(due_addr));
      free_due = 0;
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(prev_data));
        check("stall_last", 64'(out_last), 64'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", out_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(e.data));
          check("out_last", 64'(out_last), 64'(e.last));
          bytes_seen++;
          if (e.blk_end) begin
            free_due = 1;
            due_addr = e.faddr;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // out_ready driver: 0 = always ready, 1 = 1-0-0-1 pattern, 2 = random.
  int rmode = 0;
  int ph = 0;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1:       begin out_ready = pat[ph % 4]; ph++; end
        2:       out_ready = ($urandom_range(0, 9) < 7);
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Offer a descriptor; returns just after the handshake edge.
  task automatic send(input int addr, input int len);
    int t = 0;
    push_frame(addr, len);
    desc_valid = 1'b1;
    desc_addr  = AW'(addr);
    desc_len   = LW'(len);
    while (!desc_ready && t < 200) begin
      tick();
      t++;
    end
    if (!desc_ready) check("desc_ready_timeout", 64'(desc_ready), 64'd1);
    tick();
    desc_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      tick();
      t++;
    end
    repeat (3) tick();
    check("frame_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int base;
    int t;
    int gaps;
    int runs;
    bit started;
    bit in_gap;

    for (int i = 0; i < NB; i++) mem[i] = {$urandom, $urandom};

    repeat (3) tick();
    check("rst_desc_ready", 64'(desc_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_free_valid", 64'(free_valid), 64'd0);
    check("rst_r_addr", 64'(r_addr), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    rst = 1'b0;
    tick();

    // Single full block with first-byte latency.
    send(3, 8);
    check("lat_e1", 64'(out_valid), 64'd0);
    tick();
    check("lat_e2", 64'(out_valid), 64'd0);
    tick();
    check("lat_e3", 64'(out_valid), 64'd1);
    wait_done();

    // Wrap 15 -> 0 -> 1 with a 4-byte tail block.
    send(15, 20);
    wait_done();

    // Zero-length frame followed by a one-byte frame.
    send(2, 0);
    check("len0_desc_ready", 64'(desc_ready), 64'd1);
    send(4, 1);
    wait_done();

    // Backpressure pattern.
    ph = 0;
    rmode = 1;
    send(7, 16);
    wait_done();
    rmode = 0;
    tick();

    // Reset mid-frame after the fifth byte.
    base = bytes_seen;
    send(5, 16);
    t = 0;
    while (bytes_seen < base + 5 && t < 100) begin
      tick();
      t++;
    end
    check("reached_byte5", 64'(bytes_seen - base >= 5), 64'd1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_desc_ready", 64'(desc_ready), 64'd1);
    check("midrst_free_valid", 64'(free_valid), 64'd0);
    rst = 1'b0;
    tick();
    send(9, 11);
    wait_done();

    // Inter-block bubbles on a three-block frame.
    send(10, 24);
    gaps = 0;
    runs = 0;
    started = 0;
    in_gap = 0;
    t = 0;
    while (t < 200) begin
      if (out_valid) started = 1;
      if (started && !out_valid) begin
        gaps++;
        if (!in_gap) runs++;
      end
      in_gap = started && !out_valid;
      if (out_valid && out_last) break;
      tick();
      t++;
    end
`ifdef FRAME_READER_PREFETCH_EN
    check("gap_cycles", 64'(gaps), 64'd0);
    check("gap_runs", 64'(runs), 64'd0);
`else
    check("gap_cycles", 64'(gaps), 64'd4);
    check("gap_runs", 64'(runs), 64'd2);
`endif
    wait_done();

    // Random frames under random backpressure.
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < NB; i++) mem[i] = {$urandom, $urandom};
      rmode = ($urandom_range(0, 1) == 1) ? 2 : 0;
      send(int'($urandom_range(0, NB - 1)), int'($urandom_range(0, 40)));
      wait_done();
    end
    rmode = 0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
